// File: rtl/hazard_stall_unit_if.sv
// Hazard/stall controller signal bundle: pipeline-side hazard inputs and stage-control outputs.
// The master modport is the pipeline side; the slave modport is hazard_stall_unit.
interface hazard_stall_unit_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       IF_ID_rs1_i;
    logic [4:0]       IF_ID_rs2_i;
    logic             IF_ID_uses_rs1_i;
    logic             IF_ID_uses_rs2_i;
    logic [4:0]       ID_EX_rd_i;
    logic             ID_EX_mem_read_i;
    logic             ID_EX_load_regfile_i;
    logic             EX_branch_taken_i;
    logic             imem_read_i;
    logic             imem_resp_i;
    logic             dmem_read_i;
    logic             dmem_write_i;
    logic             dmem_resp_i;
    logic             PC_load_o;
    logic             IF_ID_load_o;
    logic             ID_EX_load_o;
    logic             EX_MEM_load_o;
    logic             MEM_WB_load_o;
    logic             ID_EX_bubble_o;
    logic             IF_ID_flush_o;
    logic             timeout_err_o;
    logic [CNT_W-1:0] stall_cycles_o;
    logic [CNT_W-1:0] bubble_cnt_o;

    modport master (
        output IF_ID_rs1_i, IF_ID_rs2_i, IF_ID_uses_rs1_i, IF_ID_uses_rs2_i,
               ID_EX_rd_i, ID_EX_mem_read_i, ID_EX_load_regfile_i, EX_branch_taken_i,
               imem_read_i, imem_resp_i, dmem_read_i, dmem_write_i, dmem_resp_i,
        input  PC_load_o, IF_ID_load_o, ID_EX_load_o, EX_MEM_load_o, MEM_WB_load_o,
               ID_EX_bubble_o, IF_ID_flush_o, timeout_err_o, stall_cycles_o, bubble_cnt_o
    );

    modport slave (
        input  IF_ID_rs1_i, IF_ID_rs2_i, IF_ID_uses_rs1_i, IF_ID_uses_rs2_i,
               ID_EX_rd_i, ID_EX_mem_read_i, ID_EX_load_regfile_i, EX_branch_taken_i,
               imem_read_i, imem_resp_i, dmem_read_i, dmem_write_i, dmem_resp_i,
        output PC_load_o, IF_ID_load_o, ID_EX_load_o, EX_MEM_load_o, MEM_WB_load_o,
               ID_EX_bubble_o, IF_ID_flush_o, timeout_err_o, stall_cycles_o, bubble_cnt_o
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Pipeline hold/bubble controller: load-use stalls, memory wait freezes, deferred branch flushes, watchdog.
// Optional stall/bubble performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_unit #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 32
) (
    input logic               clk_i,
    input logic               rst_n_i,
    hazard_stall_unit_if.slave hz
);
    localparam int unsigned WCW = $clog2(TIMEOUT + 1);

    typedef enum logic {S_RUN, S_WAIT} state_e;

    state_e         state_q, state_d;
    logic           flush_pending_q, flush_pending_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           timeout_err_q, timeout_err_d;

    logic freeze, lu, flush;
    logic pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic id_ex_bubble, if_id_flush;

    assign freeze = (hz.imem_read_i & ~hz.imem_resp_i)
                  | ((hz.dmem_read_i | hz.dmem_write_i) & ~hz.dmem_resp_i);
    assign lu     = hz.ID_EX_mem_read_i & hz.ID_EX_load_regfile_i & (hz.ID_EX_rd_i != 5'd0)
                  & ((hz.IF_ID_uses_rs1_i & (hz.ID_EX_rd_i == hz.IF_ID_rs1_i))
                   | (hz.IF_ID_uses_rs2_i & (hz.ID_EX_rd_i == hz.IF_ID_rs2_i)));
    assign flush  = hz.EX_branch_taken_i | flush_pending_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q         <= S_RUN;
            flush_pending_q <= 1'b0;
            wait_cnt_q      <= '0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            flush_pending_q <= flush_pending_d;
            wait_cnt_q      <= wait_cnt_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    // The release cycle of WAIT behaves like unfrozen RUN, so both share the !freeze arm.
    always_comb begin
        state_d         = state_q;
        flush_pending_d = flush_pending_q;
        wait_cnt_d      = wait_cnt_q;
        timeout_err_d   = timeout_err_q;
        pc_load         = 1'b0;
        if_id_load      = 1'b0;
        id_ex_load      = 1'b0;
        ex_mem_load     = 1'b0;
        mem_wb_load     = 1'b0;
        id_ex_bubble    = 1'b0;
        if_id_flush     = 1'b0;
        if (!freeze) begin
            pc_load         = 1'b1;
            if_id_load      = 1'b1;
            id_ex_load      = 1'b1;
            ex_mem_load     = 1'b1;
            mem_wb_load     = 1'b1;
            if (flush) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (lu) begin
                pc_load      = 1'b0;
                if_id_load   = 1'b0;
                id_ex_bubble = 1'b1;
            end
            flush_pending_d = 1'b0;
            wait_cnt_d      = '0;
            state_d         = S_RUN;
        end else begin
            if (hz.EX_branch_taken_i) flush_pending_d = 1'b1;
            state_d = S_WAIT;
            if (state_q == S_WAIT) begin
                if (wait_cnt_q != WCW'(TIMEOUT)) wait_cnt_d = wait_cnt_q + 1'b1;
                if (wait_cnt_d == WCW'(TIMEOUT - 1)) timeout_err_d = 1'b1;
            end
        end
    end

    assign hz.PC_load_o      = pc_load;
    assign hz.IF_ID_load_o   = if_id_load;
    assign hz.ID_EX_load_o   = id_ex_load;
    assign hz.EX_MEM_load_o  = ex_mem_load;
    assign hz.MEM_WB_load_o  = mem_wb_load;
    assign hz.ID_EX_bubble_o = id_ex_bubble;
    assign hz.IF_ID_flush_o  = if_id_flush;
    assign hz.timeout_err_o  = timeout_err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        bubble_cnt_d   = bubble_cnt_q;
        if (!pc_load && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
        if (id_ex_bubble && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cycles_q <= '0;
            bubble_cnt_q   <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            bubble_cnt_q   <= bubble_cnt_d;
        end
    end

    assign hz.stall_cycles_o = stall_cycles_q;
    assign hz.bubble_cnt_o   = bubble_cnt_q;
`else
    assign hz.stall_cycles_o = '0;
    assign hz.bubble_cnt_o   = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed vectors, a cycle-level behavioural model compared every cycle,
// and literal expectations for the key scenarios (counter expectations follow HAZARD_PERF_CNT_EN).
module tb_hazard_stall_unit;
    localparam int unsigned TO = 4;
    localparam int unsigned CW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    hazard_stall_unit_if #(.CNT_W(CW)) hif();
    hazard_stall_unit #(.TIMEOUT(TO), .CNT_W(CW)) dut (.clk_i(clk), .rst_n_i(rst_n), .hz(hif));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
        end
    endtask

    // Model state: length of the current frozen run, branch seen while frozen, sticky error, event counts.
    int     m_run   = 0;
    bit     m_pend  = 0;
    bit     m_err   = 0;
    longint m_stall = 0;
    longint m_bub   = 0;
    bit     chk_en  = 0;

    function automatic bit frz_f();
        return (hif.imem_read_i && !hif.imem_resp_i)
            || ((hif.dmem_read_i || hif.dmem_write_i) && !hif.dmem_resp_i);
    endfunction

    function automatic bit lu_f();
        bit dep1 = hif.IF_ID_uses_rs1_i && (hif.ID_EX_rd_i == hif.IF_ID_rs1_i);
        bit dep2 = hif.IF_ID_uses_rs2_i && (hif.ID_EX_rd_i == hif.IF_ID_rs2_i);
        return hif.ID_EX_mem_read_i && hif.ID_EX_load_regfile_i && (hif.ID_EX_rd_i != 5'd0) && (dep1 || dep2);
    endfunction

    function automatic bit squash_f();
        return hif.EX_branch_taken_i || m_pend;
    endfunction

    function automatic bit exp_front();
        return !frz_f() && !(lu_f() && !squash_f());
    endfunction

    function automatic bit exp_bub();
        return !frz_f() && (squash_f() || lu_f());
    endfunction

    function automatic logic [CW-1:0] exp_cnt(input longint v);
`ifdef HAZARD_PERF_CNT_EN
        return CW'(v);
`else
        return (v > 0) ? '0 : '0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_pend = 0; m_err = 0; m_stall = 0; m_bub = 0;
        end else begin
            if (!exp_front()) m_stall++;
            if (exp_bub()) m_bub++;
            if (frz_f()) begin
                m_run++;
                if (hif.EX_branch_taken_i) m_pend = 1;
                if (m_run >= TO) m_err = 1;
            end else begin
                m_run  = 0;
                m_pend = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_PC_load",      hif.PC_load_o,      exp_front());
            chk("m_IF_ID_load",   hif.IF_ID_load_o,   exp_front());
            chk("m_ID_EX_load",   hif.ID_EX_load_o,   !frz_f());
            chk("m_EX_MEM_load",  hif.EX_MEM_load_o,  !frz_f());
            chk("m_MEM_WB_load",  hif.MEM_WB_load_o,  !frz_f());
            chk("m_bubble",       hif.ID_EX_bubble_o, exp_bub());
            chk("m_flush",        hif.IF_ID_flush_o,  !frz_f() && squash_f());
            chk("m_timeout_err",  hif.timeout_err_o,  m_err);
            chk("m_stall_cycles", hif.stall_cycles_o, exp_cnt(m_stall));
            chk("m_bubble_cnt",   hif.bubble_cnt_o,   exp_cnt(m_bub));
        end
    end

    function automatic logic [4:0] ens();
        return {hif.PC_load_o, hif.IF_ID_load_o, hif.ID_EX_load_o, hif.EX_MEM_load_o, hif.MEM_WB_load_o};
    endfunction

    task automatic idle();
        hif.IF_ID_rs1_i = '0; hif.IF_ID_rs2_i = '0;
        hif.IF_ID_uses_rs1_i = 1'b0; hif.IF_ID_uses_rs2_i = 1'b0;
        hif.ID_EX_rd_i = '0; hif.ID_EX_mem_read_i = 1'b0; hif.ID_EX_load_regfile_i = 1'b0;
        hif.EX_branch_taken_i = 1'b0;
        hif.imem_read_i = 1'b0; hif.imem_resp_i = 1'b0;
        hif.dmem_read_i = 1'b0; hif.dmem_write_i = 1'b0; hif.dmem_resp_i = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input bit u1, input bit u2);
        hif.ID_EX_mem_read_i = 1'b1; hif.ID_EX_load_regfile_i = 1'b1; hif.ID_EX_rd_i = rd;
        hif.IF_ID_rs1_i = rs1; hif.IF_ID_rs2_i = rs2;
        hif.IF_ID_uses_rs1_i = u1; hif.IF_ID_uses_rs2_i = u2;
    endtask

    task automatic next();
        @(posedge clk); #1;
    endtask

    initial begin
        idle();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_enables", ens(), 5'b11111);
        chk("rst_err", hif.timeout_err_o, 1'b0);
        chk("rst_stall_cnt", hif.stall_cycles_o, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // Load-use on rs1, exactly one stall cycle.
        set_lu(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        #2;
        chk("lu_enables", ens(), 5'b00111);
        chk("lu_bubble", hif.ID_EX_bubble_o, 1'b1);
        chk("lu_flush", hif.IF_ID_flush_o, 1'b0);
        next(); idle(); #2;
        chk("lu_after_enables", ens(), 5'b11111);
        chk("lu_after_bubble", hif.ID_EX_bubble_o, 1'b0);
        next();

        // Data wait of three cycles, then the response cycle releases.
        hif.dmem_read_i = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            #2 chk("dw_frozen", ens(), 5'b00000);
            next();
        end
        hif.dmem_resp_i = 1'b1;
        #2 chk("dw_release", ens(), 5'b11111);
        next(); idle(); #2;
        chk("dw_after", ens(), 5'b11111);
`ifdef HAZARD_PERF_CNT_EN
        chk("cnt_stall", hif.stall_cycles_o, CW'(4));
        chk("cnt_bubble", hif.bubble_cnt_o, CW'(1));
`else
        chk("cnt_stall", hif.stall_cycles_o, '0);
        chk("cnt_bubble", hif.bubble_cnt_o, '0);
`endif
        next();

        // No stall for x0 or an unused source; rs2 dependence does stall.
        set_lu(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        #2 chk("x0_pc", hif.PC_load_o, 1'b1);
        chk("x0_bubble", hif.ID_EX_bubble_o, 1'b0);
        next();
        set_lu(5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
        #2 chk("unused_pc", hif.PC_load_o, 1'b1);
        next();
        set_lu(5'd7, 5'd1, 5'd7, 1'b0, 1'b1);
        #2 chk("rs2_pc", hif.PC_load_o, 1'b0);
        chk("rs2_bubble", hif.ID_EX_bubble_o, 1'b1);
        next(); idle(); next();

        // Branch pulse in the second frozen cycle is honoured on release.
        hif.dmem_write_i = 1'b1;
        next();
        hif.EX_branch_taken_i = 1'b1;
        #2 chk("bf_frozen_flush", hif.IF_ID_flush_o, 1'b0);
        chk("bf_frozen_en", ens(), 5'b00000);
        next();
        hif.EX_branch_taken_i = 1'b0;
        next();
        hif.dmem_resp_i = 1'b1;
        #2 chk("bf_rel_flush", hif.IF_ID_flush_o, 1'b1);
        chk("bf_rel_bubble", hif.ID_EX_bubble_o, 1'b1);
        chk("bf_rel_en", ens(), 5'b11111);
        next(); idle(); #2;
        chk("bf_after_flush", hif.IF_ID_flush_o, 1'b0);
        chk("bf_after_bubble", hif.ID_EX_bubble_o, 1'b0);
        next();

        // Flush outranks load-use in the same cycle.
        set_lu(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        hif.EX_branch_taken_i = 1'b1;
        #2 chk("fvl_flush", hif.IF_ID_flush_o, 1'b1);
        chk("fvl_bubble", hif.ID_EX_bubble_o, 1'b1);
        chk("fvl_en", ens(), 5'b11111);
        next(); idle(); next();

        // Load-use present at the release of a wait is honoured that cycle.
        set_lu(5'd9, 5'd9, 5'd0, 1'b1, 1'b0);
        hif.dmem_read_i = 1'b1;
        #2 chk("lur_frozen_bubble", hif.ID_EX_bubble_o, 1'b0);
        next(); next();
        hif.dmem_resp_i = 1'b1;
        #2 chk("lur_rel_en", ens(), 5'b00111);
        chk("lur_rel_bubble", hif.ID_EX_bubble_o, 1'b1);
        next(); idle(); next();

        // Watchdog: error after the 4th consecutive frozen cycle, sticky through release.
        hif.imem_read_i = 1'b1;
        next(); next(); next();
        chk("wd_3_err", hif.timeout_err_o, 1'b0);
        next();
        chk("wd_4_err", hif.timeout_err_o, 1'b1);
        next(); next();
        hif.imem_resp_i = 1'b1;
        #2 chk("wd_rel_err", hif.timeout_err_o, 1'b1);
        next(); idle(); #2;
        chk("wd_after_err", hif.timeout_err_o, 1'b1);
        next();

        // Reset mid-WAIT with a pending flush: async clear, pending discarded.
        hif.dmem_read_i = 1'b1;
        hif.EX_branch_taken_i = 1'b1;
        next();
        hif.EX_branch_taken_i = 1'b0;
        next();
        #2 rst_n = 1'b0;
        #1;
        chk("rw_err", hif.timeout_err_o, 1'b0);
        chk("rw_stall_cnt", hif.stall_cycles_o, '0);
        chk("rw_bubble_cnt", hif.bubble_cnt_o, '0);
        chk("rw_frozen_en", ens(), 5'b00000);
        idle();
        #1 chk("rw_flush_gone", hif.IF_ID_flush_o, 1'b0);
        chk("rw_en", ens(), 5'b11111);
        next();
        rst_n = 1'b1;
        #2 chk("rw_post_flush", hif.IF_ID_flush_o, 1'b0);
        chk("rw_post_bubble", hif.ID_EX_bubble_o, 1'b0);
        next(); next();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
